// File: rtl/add_round_key_seq_if.sv
// Stream and key-load bundle for add_round_key_seq: key bank writes, the
// state-block input handshake and the result output handshake.
interface add_round_key_seq_if #(
    parameter int DATA_W = 128,
    parameter int KIDX_W = 4
);
    logic              key_wr_en;
    logic [KIDX_W-1:0] key_wr_idx;
    logic [DATA_W-1:0] key_wr_data;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [KIDX_W-1:0] in_kidx;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    logic              busy;

    // Driven by the round controller / key expansion side.
    modport master (
        output key_wr_en, key_wr_idx, key_wr_data,
        output in_valid, in_data, in_kidx, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data,
        input  in_valid, in_data, in_kidx, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/add_round_key_seq.sv
// Sequential AES AddRoundKey: snapshots a round key from a writable bank on
// accept, XORs it into the state one SLICE_W slice per clock, then holds the result.
module add_round_key_seq #(
    parameter int DATA_W   = 128,
    parameter int SLICE_W  = 32,
    parameter int NUM_KEYS = 11,
    parameter int KIDX_W   = 4
) (
    input logic                clk,
    input logic                rst,
    add_round_key_seq_if.slave bus
);
    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;

    logic [DATA_W-1:0] r_bank [NUM_KEYS];
    logic [DATA_W-1:0] r_work;
    logic [DATA_W-1:0] r_key;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [DATA_W-1:0] w_key_rd;
    logic              w_kidx_bad;
    logic [DATA_W-1:0] w_work_nxt;

    // NOTE: the bank is a plain register file with a reset, not an inferred RAM,
    // because a reset must clear every round key to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (bus.key_wr_en) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (bus.key_wr_idx == KIDX_W'(k)) begin
                    r_bank[k] <= bus.key_wr_data;
                end
            end
        end
    end

    // Out-of-range indices read as zero and are flagged; a write in the
    // accept cycle is not yet visible here, so the block gets the old key.
    always_comb begin
        w_key_rd   = '0;
        w_kidx_bad = 1'b1;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (bus.in_kidx == KIDX_W'(k)) begin
                w_key_rd   = r_bank[k];
                w_kidx_bad = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.busy     = 1'b0;
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_SLICE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Only the slice selected by r_cnt changes; an erroring block passes through.
    always_comb begin
        w_work_nxt = r_work;
        if (!r_err) begin
            for (int s = 0; s < N; s++) begin
                if (r_cnt == CNT_W'(s)) begin
                    w_work_nxt[s*SLICE_W +: SLICE_W] =
                        r_work[s*SLICE_W +: SLICE_W] ^ r_key[s*SLICE_W +: SLICE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_key  <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= bus.in_data;
            r_key  <= w_key_rd;
            r_err  <= w_kidx_bad;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_work <= w_work_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign bus.out_data = r_work;
    assign bus.out_err  = r_err;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Scoreboarded bench for add_round_key_seq: directed FIPS-197, snapshot,
// out-of-range, backpressure and mid-run reset cases, plus a SLICE_W sweep.
module tb_add_round_key_seq;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ONES     = {128{1'b1}};
    localparam logic [127:0] A5S      = {16{8'hA5}};
    localparam logic [127:0] PAT      = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PAT_N    = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] P_DATA   = 128'hdeadbeefcafef00d123456789abcdef0;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_round_key_seq_if #(.DATA_W(128), .KIDX_W(4)) bus ();
    add_round_key_seq_if #(.DATA_W(128), .KIDX_W(4)) bus128 ();
    add_round_key_seq_if #(.DATA_W(128), .KIDX_W(4)) bus8 ();

    add_round_key_seq u_dut (.clk(clk), .rst(rst), .bus(bus));
    add_round_key_seq #(.SLICE_W(128)) u_w128 (.clk(clk), .rst(rst), .bus(bus128));
    add_round_key_seq #(.SLICE_W(8))   u_w8   (.clk(clk), .rst(rst), .bus(bus8));

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   rise_cyc = 0;
    int   valid_len = 0;
    int   last_valid_len = 0;
    logic prev_valid = 1'b0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (!prev_valid) rise_cyc = cyc;
            valid_len++;
            if (bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    timeout("unexpected_output");
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_err", {127'b0, bus.out_err}, {127'b0, e.err});
                end
            end
        end else if (prev_valid) begin
            last_valid_len = valid_len;
            valid_len      = 0;
        end
        prev_valid = bus.out_valid && !rst;
    end

    task automatic write_key(input logic [3:0] idx, input logic [127:0] data);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = idx;
        bus.key_wr_data = data;
        @(posedge clk);
        #1;
        bus.key_wr_en   = 1'b0;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (i == 100) timeout("accept");
        acc_cyc = cyc + 1;
    endtask

    task automatic send(input logic [127:0] d, input logic [3:0] k,
                        input logic [127:0] ed, input logic ee);
        sb_q.push_back('{data: ed, err: ee});
        bus.in_data  = d;
        bus.in_kidx  = k;
        bus.in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_kidx  = ~k;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !bus.busy) break;
        end
        if (i == 200) timeout("drain");
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat128, lat8;
        logic [127:0] d128, d8;

        bus.key_wr_en = 0; bus.key_wr_idx = '0; bus.key_wr_data = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_kidx = '0; bus.out_ready = 1;
        bus128.key_wr_en = 0; bus128.key_wr_idx = '0; bus128.key_wr_data = '0;
        bus128.in_valid = 0; bus128.in_data = '0; bus128.in_kidx = '0; bus128.out_ready = 1;
        bus8.key_wr_en = 0; bus8.key_wr_idx = '0; bus8.key_wr_data = '0;
        bus8.in_valid = 0; bus8.in_data = '0; bus8.in_kidx = '0; bus8.out_ready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rst_busy", {127'b0, bus.busy}, 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;

        // FIPS-197 round 0
        write_key(4'd0, FIPS_KEY);
        send(FIPS_PT, 4'd0, FIPS_CT, 1'b0);
        wait_drain();
        check("fips_latency", 128'(rise_cyc - acc_cyc), 128'd4);
        check("fips_valid_len", 128'(last_valid_len), 128'd1);

        // Snapshot with a same-cycle write to the accepted index
        write_key(4'd3, ONES);
        sb_q.push_back('{data: 128'd0, err: 1'b0});
        bus.in_data = ONES; bus.in_kidx = 4'd3; bus.in_valid = 1'b1;
        bus.key_wr_en = 1'b1; bus.key_wr_idx = 4'd3; bus.key_wr_data = 128'd0;
        @(negedge clk);
        check("snap_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.key_wr_en = 1'b0;
        send(ONES, 4'd3, ONES, 1'b0);
        wait_drain();

        // Out-of-range indices and dropped bank writes
        send(A5S, 4'd12, A5S, 1'b1);
        send(A5S, 4'd11, A5S, 1'b1);
        write_key(4'd10, PAT);
        write_key(4'd12, ONES);
        send(128'd0, 4'd0, FIPS_KEY, 1'b0);
        send(128'd0, 4'd10, PAT, 1'b0);
        send(128'd0, 4'd3, 128'd0, 1'b0);
        wait_drain();

        // Backpressure with a second block offered throughout
        bus.out_ready = 1'b0;
        send(ONES, 4'd10, PAT_N, 1'b0);
        sb_q.push_back('{data: FIPS_KEY, err: 1'b0});
        bus.in_data = 128'd0; bus.in_kidx = 4'd0; bus.in_valid = 1'b1;
        begin
            int i;
            for (i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.out_valid) break;
            end
            if (i == 50) timeout("bp_out_valid");
        end
        repeat (10) begin
            check("bp_out_valid", {127'b0, bus.out_valid}, 128'd1);
            check("bp_out_data", bus.out_data, PAT_N);
            check("bp_in_ready", {127'b0, bus.in_ready}, 128'd0);
            check("bp_busy", {127'b0, bus.busy}, 128'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_accepted", {127'b0, bus.busy}, 128'd1);
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset at slice 2 aborts the block and clears the bank
        bus.in_data = P_DATA; bus.in_kidx = 4'd0; bus.in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.key_wr_en = 1'b1; bus.key_wr_idx = 4'd0; bus.key_wr_data = ONES;
        @(negedge clk);
        check("mid_busy", {127'b0, bus.busy}, 128'd1);
        check("mid_rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.key_wr_en = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("abort_out_data", bus.out_data, 128'd0);
        check("abort_out_err", {127'b0, bus.out_err}, 128'd0);
        check("abort_busy", {127'b0, bus.busy}, 128'd0);
        check("abort_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;
        send(P_DATA, 4'd0, P_DATA, 1'b0);
        send(128'd0, 4'd10, 128'd0, 1'b0);
        wait_drain();

        // SLICE_W sweep: 128 and 8 bits per cycle
        bus128.key_wr_en = 1'b1; bus128.key_wr_idx = 4'd0; bus128.key_wr_data = FIPS_KEY;
        bus8.key_wr_en = 1'b1;   bus8.key_wr_idx = 4'd0;   bus8.key_wr_data = FIPS_KEY;
        @(posedge clk);
        #1;
        bus128.key_wr_en = 1'b0; bus8.key_wr_en = 1'b0;
        bus128.in_data = FIPS_PT; bus128.in_kidx = 4'd0; bus128.in_valid = 1'b1;
        bus8.in_data = FIPS_PT;   bus8.in_kidx = 4'd0;   bus8.in_valid = 1'b1;
        @(negedge clk);
        check("sweep_in_ready", {126'b0, bus128.in_ready, bus8.in_ready}, 128'd3);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus128.in_valid = 1'b0; bus8.in_valid = 1'b0;
        lat128 = -1; lat8 = -1; d128 = '0; d8 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus128.out_valid && lat128 < 0) begin
                lat128 = cyc - acc_cyc;
                d128   = bus128.out_data;
            end
            if (bus8.out_valid && lat8 < 0) begin
                lat8 = cyc - acc_cyc;
                d8   = bus8.out_data;
            end
        end
        check("w128_data", d128, FIPS_CT);
        check("w8_data", d8, FIPS_CT);
        check("w128_latency", 128'(lat128), 128'd1);
        check("w8_latency", 128'(lat8), 128'd16);

        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
